// File: rtl/uart_tx_fifo_feeder_if.sv
// Host write port plus UART TX launch/status handshake for uart_tx_fifo_feeder.
// slave is the feeder's view; master is the host/UART side that drives it.
interface uart_tx_fifo_feeder_if #(
  parameter int DEPTH = 16
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          i_Wr_En;
  logic [7:0]    i_Wr_Byte;
  logic          i_Clr_Overflow;
  logic          o_Full;
  logic          o_Empty;
  logic [CW-1:0] o_Count;
  logic          o_Overflow;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic          i_Tx_Active;
  logic          i_Tx_Done;

  modport slave (
    input  i_Wr_En,
    input  i_Wr_Byte,
    input  i_Clr_Overflow,
    output o_Full,
    output o_Empty,
    output o_Count,
    output o_Overflow,
    output o_Tx_DV,
    output o_Tx_Byte,
    input  i_Tx_Active,
    input  i_Tx_Done
  );

  modport master (
    output i_Wr_En,
    output i_Wr_Byte,
    output i_Clr_Overflow,
    input  o_Full,
    input  o_Empty,
    input  o_Count,
    input  o_Overflow,
    input  o_Tx_DV,
    input  o_Tx_Byte,
    output i_Tx_Active,
    output i_Tx_Done
  );
endinterface

// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO that meters host writes into a UART transmitter, one frame at a time.
// Define UART_TX_FIFO_STATS_EN to add saturating o_Sent_Cnt / o_Drop_Cnt counters.
module uart_tx_fifo_feeder #(
  parameter int DEPTH        = 16,
  parameter int GUARD_CYCLES = 2
) (
  input logic                  i_Clock,
  input logic                  i_Rst_L,
  uart_tx_fifo_feeder_if.slave bus
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]          o_Sent_Cnt,
  output logic [15:0]          o_Drop_Cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    BUSY,
    GUARD
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, wrPtr_d;
  logic [AW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          overflow_q, overflow_d;

  state_t        state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic          txDv_q, txDv_d;
  logic [7:0]    txByte_q, txByte_d;

  logic          wrAccept;
  logic          wrDrop;
  logic          pop;

  // Acceptance uses the registered full flag, so a pop in the same cycle never rescues a write.
  assign wrAccept = bus.i_Wr_En && !full_q;
  assign wrDrop   = bus.i_Wr_En && full_q;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + AW'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + AW'(1);
    end
    if (wrAccept && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wrAccept && pop) begin
      count_d = count_q - CW'(1);
    end
    if (wrDrop) begin
      overflow_d = 1'b1;
    end else if (bus.i_Clr_Overflow) begin
      overflow_d = 1'b0;
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wrAccept) begin
      mem_q[wrPtr_q] <= bus.i_Wr_Byte;
    end
  end

  // IDLE also waits on i_Tx_Active: the UART is not reset with us and may still be mid-frame.
  always_comb begin
    state_d  = state_q;
    guard_d  = guard_q;
    txDv_d   = 1'b0;
    txByte_d = txByte_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty_q && !bus.i_Tx_Active) begin
          pop      = 1'b1;
          txDv_d   = 1'b1;
          txByte_d = mem_q[rdPtr_q];
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = BUSY;
      end
      BUSY: begin
        if (bus.i_Tx_Done) begin
          if (GUARD_CYCLES > 1) begin
            state_d = GUARD;
            guard_d = GW'(GUARD_CYCLES - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      GUARD: begin
        if (guard_q <= GW'(1)) begin
          state_d = IDLE;
        end else begin
          guard_d = guard_q - GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      guard_q  <= '0;
      txDv_q   <= 1'b0;
      txByte_q <= 8'h00;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      txDv_q   <= txDv_d;
      txByte_q <= txByte_d;
    end
  end

  assign bus.o_Full     = full_q;
  assign bus.o_Empty    = empty_q;
  assign bus.o_Count    = count_q;
  assign bus.o_Overflow = overflow_q;
  assign bus.o_Tx_DV    = txDv_q;
  assign bus.o_Tx_Byte  = txByte_q;

`ifdef UART_TX_FIFO_STATS_EN
  logic        frameDone;
  logic [15:0] sentCnt_q, sentCnt_d;
  logic [15:0] dropCnt_q, dropCnt_d;

  assign frameDone = (state_q == BUSY) && bus.i_Tx_Done;

  always_comb begin
    sentCnt_d = sentCnt_q;
    dropCnt_d = dropCnt_q;
    if (frameDone && (sentCnt_q != 16'hFFFF)) begin
      sentCnt_d = sentCnt_q + 16'd1;
    end
    if (wrDrop && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sentCnt_q <= '0;
      dropCnt_q <= '0;
    end else begin
      sentCnt_q <= sentCnt_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign o_Sent_Cnt = sentCnt_q;
  assign o_Drop_Cnt = dropCnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with a small behavioural UART TX model.
// Also builds with UART_TX_FIFO_STATS_EN defined to cover the stats counters.
module tb_uart_tx_fifo_feeder;
  localparam int DEPTH = 16;
  localparam int GUARD = 4;
  localparam int FRAME = 12;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk  = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  uart_tx_fifo_feeder_if #(.DEPTH(DEPTH)) bus ();

  logic forceActive = 1'b0;
  logic forceDone   = 1'b0;
  logic modelActive = 1'b0;
  logic modelDone   = 1'b0;
  assign bus.i_Tx_Active = modelActive | forceActive;
  assign bus.i_Tx_Done   = modelDone | forceDone;

`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0] sentCnt;
  logic [15:0] dropCnt;
`endif

  uart_tx_fifo_feeder #(
    .DEPTH       (DEPTH),
    .GUARD_CYCLES(GUARD)
  ) dut (
    .i_Clock   (clk),
    .i_Rst_L   (rstN),
    .bus       (bus)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .o_Sent_Cnt(sentCnt),
    .o_Drop_Cnt(dropCnt)
`endif
  );

  int checks   = 0;
  int passed   = 0;
  int cyc      = 0;
  int frameCnt = 0;
  int protoErr = 0;
  logic [7:0] rxQ[$];
  int dvCycQ[$];
  int doneCycQ[$];

  // UART TX stand-in: takes a launch only when idle, stays active FRAME cycles, then pulses done.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    modelDone <= 1'b0;
    if (bus.o_Tx_DV && modelActive) protoErr++;
    if (bus.o_Tx_DV && !modelActive) begin
      modelActive <= 1'b1;
      frameCnt    <= FRAME;
      rxQ.push_back(bus.o_Tx_Byte);
      dvCycQ.push_back(cyc);
    end else if (modelActive) begin
      if (frameCnt <= 1) begin
        modelActive <= 1'b0;
        modelDone   <= 1'b1;
        doneCycQ.push_back(cyc + 1);
      end else begin
        frameCnt <= frameCnt - 1;
      end
    end
  end

  task automatic applyReset();
    bus.i_Wr_En        = 1'b0;
    bus.i_Wr_Byte      = 8'h00;
    bus.i_Clr_Overflow = 1'b0;
    forceActive        = 1'b0;
    forceDone          = 1'b0;
    rstN               = 1'b0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitDrain(input int nBytes, input int budget, output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (rxQ.size() >= nBytes && bus.o_Empty && !modelActive && !modelDone) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) repeat (GUARD + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_Wr_En        = 1'b0;
    bus.i_Wr_Byte      = 8'h00;
    bus.i_Clr_Overflow = 1'b0;
    rstN               = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_Empty !== 1'b1) $display("[TB] FAIL reset_empty: got %b expected 1", bus.o_Empty); else passed++;
    checks++; if (bus.o_Full !== 1'b0) $display("[TB] FAIL reset_full: got %b expected 0", bus.o_Full); else passed++;
    checks++; if (bus.o_Count !== CW'(0)) $display("[TB] FAIL reset_count: got %0d expected 0", bus.o_Count); else passed++;
    checks++; if (bus.o_Overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", bus.o_Overflow); else passed++;
    checks++; if (bus.o_Tx_DV !== 1'b0) $display("[TB] FAIL reset_txdv: got %b expected 0", bus.o_Tx_DV); else passed++;
    checks++; if (bus.o_Tx_Byte !== 8'h00) $display("[TB] FAIL reset_txbyte: got %h expected 00", bus.o_Tx_Byte); else passed++;
    rstN = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.o_Tx_DV !== 1'b0) $display("[TB] FAIL idle_no_launch: got %b expected 0", bus.o_Tx_DV); else passed++;
  endtask

  task automatic test_single_byte();
    bit ok;
    rxQ.delete();
    @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'hA5;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    checks++; if (bus.o_Count !== CW'(1)) $display("[TB] FAIL single_count_e0: got %0d expected 1", bus.o_Count); else passed++;
    checks++; if (bus.o_Empty !== 1'b0) $display("[TB] FAIL single_empty_e0: got %b expected 0", bus.o_Empty); else passed++;
    checks++; if (bus.o_Tx_DV !== 1'b0) $display("[TB] FAIL single_dv_e0: got %b expected 0", bus.o_Tx_DV); else passed++;
    @(negedge clk);
    checks++; if (bus.o_Tx_DV !== 1'b1) $display("[TB] FAIL single_dv_e1: got %b expected 1", bus.o_Tx_DV); else passed++;
    checks++; if (bus.o_Tx_Byte !== 8'hA5) $display("[TB] FAIL single_byte_e1: got %h expected a5", bus.o_Tx_Byte); else passed++;
    checks++; if (bus.o_Count !== CW'(0)) $display("[TB] FAIL single_count_e1: got %0d expected 0", bus.o_Count); else passed++;
    checks++; if (bus.o_Empty !== 1'b1) $display("[TB] FAIL single_empty_e1: got %b expected 1", bus.o_Empty); else passed++;
    @(negedge clk);
    checks++; if (bus.o_Tx_DV !== 1'b0) $display("[TB] FAIL single_dv_pulse: got %b expected 0", bus.o_Tx_DV); else passed++;
    checks++; if (bus.o_Tx_Byte !== 8'hA5) $display("[TB] FAIL single_byte_hold: got %h expected a5", bus.o_Tx_Byte); else passed++;
    waitDrain(1, 100, ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL single_drain_timeout: got %b expected 1", ok); else passed++;
    checks++; if (rxQ.size() !== 1 || rxQ[0] !== 8'hA5) $display("[TB] FAIL single_rx: got %0d bytes first %h expected 1 byte a5", rxQ.size(), (rxQ.size() > 0) ? rxQ[0] : 8'hxx); else passed++;
  endtask

  task automatic test_burst();
    bit ok;
    int errBase;
    rxQ.delete(); dvCycQ.delete(); doneCycQ.delete();
    errBase     = protoErr;
    forceActive = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'(i);
    end
    @(negedge clk); bus.i_Wr_En = 1'b0;
    checks++; if (bus.o_Full !== 1'b1) $display("[TB] FAIL burst_full: got %b expected 1", bus.o_Full); else passed++;
    checks++; if (bus.o_Count !== CW'(16)) $display("[TB] FAIL burst_count: got %0d expected 16", bus.o_Count); else passed++;
    forceActive = 1'b0;
    waitDrain(16, 16 * (FRAME + GUARD + 8) + 50, ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL burst_drain_timeout: got %b expected 1", ok); else passed++;
    checks++; if (rxQ.size() !== 16) $display("[TB] FAIL burst_rx_count: got %0d expected 16", rxQ.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] got;
      got = (rxQ.size() > i) ? rxQ[i] : 8'hxx;
      checks++; if (got !== 8'(i)) $display("[TB] FAIL burst_order[%0d]: got %h expected %h", i, got, 8'(i)); else passed++;
    end
    for (int i = 0; i < 15; i++) begin
      int gap;
      gap = (dvCycQ.size() > i + 1 && doneCycQ.size() > i) ? dvCycQ[i + 1] - doneCycQ[i] : -1;
      checks++; if (gap !== GUARD + 1) $display("[TB] FAIL guard_spacing[%0d]: got %0d cycles expected %0d", i, gap, GUARD + 1); else passed++;
    end
    checks++; if (protoErr !== errBase) $display("[TB] FAIL burst_launch_while_active: got %0d expected %0d", protoErr, errBase); else passed++;
  endtask

  task automatic test_overflow();
    bit ok;
    applyReset();
    rxQ.delete();
    forceActive = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'h40 + 8'(i);
    end
    @(negedge clk); bus.i_Wr_Byte = 8'hFF;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    checks++; if (bus.o_Count !== CW'(16)) $display("[TB] FAIL ovf_count: got %0d expected 16", bus.o_Count); else passed++;
    checks++; if (bus.o_Overflow !== 1'b1) $display("[TB] FAIL ovf_set: got %b expected 1", bus.o_Overflow); else passed++;
    bus.i_Clr_Overflow = 1'b1;
    @(negedge clk); bus.i_Clr_Overflow = 1'b0;
    checks++; if (bus.o_Overflow !== 1'b0) $display("[TB] FAIL ovf_clear: got %b expected 0", bus.o_Overflow); else passed++;
    bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'hFF; bus.i_Clr_Overflow = 1'b1;
    @(negedge clk); bus.i_Wr_En = 1'b0; bus.i_Clr_Overflow = 1'b0;
    checks++; if (bus.o_Overflow !== 1'b1) $display("[TB] FAIL ovf_set_beats_clear: got %b expected 1", bus.o_Overflow); else passed++;
    checks++; if (bus.o_Count !== CW'(16)) $display("[TB] FAIL ovf_count2: got %0d expected 16", bus.o_Count); else passed++;
    bus.i_Clr_Overflow = 1'b1;
    @(negedge clk); bus.i_Clr_Overflow = 1'b0;
    forceActive = 1'b0; bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'hEE;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    checks++; if (bus.o_Count !== CW'(15)) $display("[TB] FAIL ovf_full_pop_count: got %0d expected 15", bus.o_Count); else passed++;
    checks++; if (bus.o_Overflow !== 1'b1) $display("[TB] FAIL ovf_full_pop_drop: got %b expected 1", bus.o_Overflow); else passed++;
    checks++; if (bus.o_Tx_DV !== 1'b1 || bus.o_Tx_Byte !== 8'h40) $display("[TB] FAIL ovf_first_launch: got dv %b byte %h expected dv 1 byte 40", bus.o_Tx_DV, bus.o_Tx_Byte); else passed++;
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (dropCnt !== 16'd3) $display("[TB] FAIL stats_drop_cnt: got %0d expected 3", dropCnt); else passed++;
`endif
    bus.i_Clr_Overflow = 1'b1;
    @(negedge clk); bus.i_Clr_Overflow = 1'b0;
    waitDrain(16, 16 * (FRAME + GUARD + 8) + 50, ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL ovf_drain_timeout: got %b expected 1", ok); else passed++;
    checks++; if (rxQ.size() !== 16) $display("[TB] FAIL ovf_rx_count: got %0d expected 16", rxQ.size()); else passed++;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] got;
      got = (rxQ.size() > i) ? rxQ[i] : 8'hxx;
      checks++; if (got !== 8'h40 + 8'(i)) $display("[TB] FAIL ovf_order[%0d]: got %h expected %h", i, got, 8'h40 + 8'(i)); else passed++;
    end
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (sentCnt !== 16'd16) $display("[TB] FAIL stats_sent_cnt: got %0d expected 16", sentCnt); else passed++;
    checks++; if (dropCnt !== 16'd3) $display("[TB] FAIL stats_drop_not_cleared: got %0d expected 3", dropCnt); else passed++;
`endif
  endtask

  task automatic test_simul_write_pop();
    bit ok;
    rxQ.delete();
    forceActive = 1'b1;
    @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'h77;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    checks++; if (bus.o_Count !== CW'(1)) $display("[TB] FAIL simul_pre_count: got %0d expected 1", bus.o_Count); else passed++;
    forceActive = 1'b0; bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'h3C;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    checks++; if (bus.o_Count !== CW'(1)) $display("[TB] FAIL simul_count: got %0d expected 1", bus.o_Count); else passed++;
    checks++; if (bus.o_Tx_DV !== 1'b1 || bus.o_Tx_Byte !== 8'h77) $display("[TB] FAIL simul_launch: got dv %b byte %h expected dv 1 byte 77", bus.o_Tx_DV, bus.o_Tx_Byte); else passed++;
    waitDrain(2, 200, ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL simul_drain_timeout: got %b expected 1", ok); else passed++;
    checks++; if (rxQ.size() !== 2 || rxQ[0] !== 8'h77 || rxQ[1] !== 8'h3C) $display("[TB] FAIL simul_rx: got %0d bytes expected 77 then 3c", rxQ.size()); else passed++;
  endtask

  task automatic test_stray_done();
    bit ok;
    rxQ.delete();
    forceActive = 1'b1;
    @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'h99;
    @(negedge clk); bus.i_Wr_En = 1'b0; forceDone = 1'b1;
    @(negedge clk); forceDone = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_Tx_DV !== 1'b0) $display("[TB] FAIL stray_done_dv: got %b expected 0", bus.o_Tx_DV); else passed++;
    checks++; if (bus.o_Count !== CW'(1)) $display("[TB] FAIL stray_done_count: got %0d expected 1", bus.o_Count); else passed++;
    forceActive = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_Tx_DV !== 1'b1 || bus.o_Tx_Byte !== 8'h99) $display("[TB] FAIL stray_launch: got dv %b byte %h expected dv 1 byte 99", bus.o_Tx_DV, bus.o_Tx_Byte); else passed++;
    waitDrain(1, 100, ok);
    checks++; if (ok !== 1'b1 || rxQ.size() !== 1 || rxQ[0] !== 8'h99) $display("[TB] FAIL stray_rx: got ok %b with %0d bytes expected 1 byte 99", ok, rxQ.size()); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int n = 0;
    int earlyDv = 0;
    int errBase;
    rxQ.delete();
    errBase = protoErr;
    @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'h11;
    @(negedge clk); bus.i_Wr_Byte = 8'h22;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (modelActive !== 1'b1) $display("[TB] FAIL midframe_uart_busy: got %b expected 1", modelActive); else passed++;
    checks++; if (bus.o_Count !== CW'(1)) $display("[TB] FAIL midframe_pre_count: got %0d expected 1", bus.o_Count); else passed++;
    #2 rstN = 1'b0;
    #1;
    checks++; if (bus.o_Count !== CW'(0) || bus.o_Empty !== 1'b1) $display("[TB] FAIL async_reset_fifo: got count %0d empty %b expected 0 1", bus.o_Count, bus.o_Empty); else passed++;
    checks++; if (bus.o_Tx_Byte !== 8'h00) $display("[TB] FAIL async_reset_byte: got %h expected 00", bus.o_Tx_Byte); else passed++;
    @(negedge clk); rstN = 1'b1;
    @(negedge clk); bus.i_Wr_En = 1'b1; bus.i_Wr_Byte = 8'h5A;
    @(negedge clk); bus.i_Wr_En = 1'b0;
    while (modelActive && n < 4 * FRAME) begin
      if (bus.o_Tx_DV) earlyDv++;
      @(negedge clk);
      n++;
    end
    checks++; if (earlyDv !== 0 || modelActive !== 1'b0) $display("[TB] FAIL midframe_gating: got %0d early launches active %b expected 0 0", earlyDv, modelActive); else passed++;
    waitDrain(2, 200, ok);
    checks++; if (ok !== 1'b1) $display("[TB] FAIL midframe_drain_timeout: got %b expected 1", ok); else passed++;
    checks++; if (rxQ.size() !== 2 || rxQ[0] !== 8'h11 || rxQ[1] !== 8'h5A) $display("[TB] FAIL midframe_rx: got %0d bytes expected 11 then 5a", rxQ.size()); else passed++;
    checks++; if (protoErr !== errBase) $display("[TB] FAIL midframe_launch_while_active: got %0d expected %0d", protoErr, errBase); else passed++;
`ifdef UART_TX_FIFO_STATS_EN
    checks++; if (sentCnt !== 16'd1) $display("[TB] FAIL stats_sent_after_reset: got %0d expected 1", sentCnt); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_simul_write_pop();
    test_stray_done();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule

// File: doc/uart_tx_fifo_feeder.md
Name: uart_tx_fifo_feeder

Overview:
- Byte-buffering front end that sits directly upstream of the UART transmit/receive top level and drives its i_Tx_DV / i_Tx_Byte inputs.
- Accepts bytes from a host-side write strobe into a synchronous FIFO.
- Launches one byte into the UART transmitter at a time, and waits for that frame's o_Tx_Done before launching the next.
- Lets software/testbench push bursts without tracking UART timing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, ≥2.
- GUARD_CYCLES, 2, idle cycles held after i_Tx_Done before the next launch; covers transmitter cleanup; ≥1.

Ports:
- i_Clock  input  1  system clock; all logic on its rising edge.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Wr_En  input  1  host write strobe; one byte per cycle while high.
- i_Wr_Byte  input  8  host write data, sampled when i_Wr_En=1.
- i_Clr_Overflow  input  1  clears o_Overflow.
- o_Full  output  1  FIFO holds DEPTH entries.
- o_Empty  output  1  FIFO holds 0 entries.
- o_Count  output  $clog2(DEPTH+1)  current occupancy.
- o_Overflow  output  1  sticky flag: a write was dropped.
- o_Tx_DV  output  1  launch pulse to UART TX (i_Tx_DV).
- o_Tx_Byte  output  8  byte to UART TX (i_Tx_Byte); valid while o_Tx_DV=1.
- i_Tx_Active  input  1  from UART o_Tx_Active.
- i_Tx_Done  input  1  from UART o_Tx_Done; 1-cycle pulse at end of stop bit.

Behaviour:
Reset:
- i_Rst_L=0 asynchronously clears pointers, count, FSM (to IDLE), o_Tx_DV, o_Tx_Byte (8'h00) and o_Overflow.
- Reset values: o_Empty=1, o_Full=0, o_Count=0.
- FIFO contents are discarded.
- The UART has no reset and may still be mid-frame after ours is released. This is handled by the IDLE launch gating below.

FIFO:
- Write accepted when i_Wr_En=1 and o_Full=0, using registered flags.
- Write with o_Full=1 is dropped and sets o_Overflow, even if a pop occurs in the same cycle.
- o_Count: +1 on write only; -1 on pop only; unchanged on simultaneous write+pop.
- Pointers wrap modulo DEPTH.
- Flags are registered and consistent with o_Count in the same cycle.

o_Overflow:
- Sticky until i_Clr_Overflow=1.
- If set and clear occur in the same cycle, set wins.

FSM states: IDLE, LAUNCH, BUSY, GUARD.
- IDLE: if o_Empty=0 and i_Tx_Active=0, then on the next edge:
  - o_Tx_DV<=1 and o_Tx_Byte<=head entry;
  - pop the head;
  - go to LAUNCH.
- LAUNCH: o_Tx_DV is high for exactly this one cycle. Next edge: o_Tx_DV<=0, go to BUSY.
- BUSY: wait for i_Tx_Done=1, then go to GUARD with a guard counter loaded with GUARD_CYCLES-1. o_Tx_Byte holds its value.
- GUARD: decrement the counter each cycle; at 0 go to IDLE.

Timing and ordering:
- Latency: write sampled at edge E0 into an empty FIFO with the UART idle → o_Tx_DV high in the cycle after edge E1.
- Minimum spacing between launches: frame time + GUARD_CYCLES + 1 cycle.
- Bytes are transmitted strictly in write order; none are duplicated or skipped.
- i_Tx_Done outside BUSY is ignored.

Optional Feature:
UART_TX_FIFO_STATS_EN
- Defined: adds ports o_Sent_Cnt[15:0] and o_Drop_Cnt[15:0].
  - o_Sent_Cnt increments on each i_Tx_Done received in BUSY.
  - o_Drop_Cnt increments on each dropped write.
  - Both saturate at 16'hFFFF and reset to 0.
  - Neither is cleared by i_Clr_Overflow.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Single byte: write 8'hA5 into an empty FIFO at edge E0 → o_Tx_DV pulses 1 cycle after E1 with o_Tx_Byte=8'hA5; UART o_Rx_DV later reports 8'hA5; o_Count returns to 0.
- Burst: 16 back-to-back writes 8'h00..8'h0F (DEPTH=16) → o_Full=1 after the 16th accepted write; all 16 bytes received over loopback in order; exactly one o_Tx_DV per i_Tx_Done+guard period.
- Overflow: fill 16 entries while the UART is busy, then write 8'hFF → write dropped, o_Overflow=1, o_Count stays 16. i_Clr_Overflow → o_Overflow=0. With STATS_EN, o_Drop_Cnt=1.
- Simultaneous write+pop: FIFO holding 1 byte, write 8'h3C on the cycle IDLE pops → o_Count unchanged; 8'h3C transmitted next.
- Reset mid-frame: assert i_Rst_L=0 while i_Tx_Active=1, then write 8'h5A after release → no o_Tx_DV until i_Tx_Active=0; then 8'h5A is launched.
- Guard spacing: GUARD_CYCLES=4, two queued bytes → the second o_Tx_DV rises exactly 5 cycles after the first byte's i_Tx_Done pulse.
